// File: rtl/log_pkg.sv
// Shared types and constants for the capture-session controller.
package log_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  localparam logic [4:0]  HDR_TAG = 5'b10100;
  localparam logic [15:0] PAD     = 16'h8000;

  function automatic logic [15:0] hdr_word(input logic [2:0] rate, input logic [7:0] seq);
    return {HDR_TAG, rate, seq};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered storage; the head is visible the cycle after push.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/log_sequencer.sv
// Capture-session controller: settles the decimator, then packs samples into header-led blocks.
// Stream output is combinational from state/FIFO head and holds until wr_ready; FIFO overflow is sticky in overrun.
module log_sequencer
  import log_pkg::*;
#(
  parameter int BLOCK_WORDS = 256,
  parameter int FIFO_DEPTH  = 16,
  parameter int SETTLE      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [2:0]  rate_cfg,
  input  logic [15:0] num_blocks,
  output logic [2:0]  rate,
  output logic        dec_reset,
  input  logic        drdy,
  input  logic [15:0] sample,
  output logic [15:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        wr_sof,
  output logic        wr_eof,
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  localparam int WCW = $clog2(BLOCK_WORDS);
  localparam int SCW = $clog2(SETTLE + 1);

  state_e          state_q, state_d;
  logic [2:0]      rate_q, rate_d;
  logic [15:0]     nblk_q, nblk_d, blkcnt_q, blkcnt_d;
  logic [7:0]      seq_q, seq_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic            ovr_q, ovr_d, done_q;

  logic            fifo_rst, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0]     fifo_head;
  logic            from_fifo, last_word, fire;

  // The FIFO is held empty whenever the session is (or is about to be) idle.
  assign fifo_rst  = reset || (state_d == ST_IDLE);
  assign fifo_push = drdy && (state_q == ST_RUN);
  assign fifo_pop  = fire && from_fifo;

  sync_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (fifo_rst),
    .push      (fifo_push),
    .push_data (sample),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_sof    = 1'b0;
    wr_eof    = 1'b0;
    from_fifo = 1'b0;
    last_word = (wcnt_q == WCW'(BLOCK_WORDS - 1));
    if (state_q == ST_RUN || state_q == ST_DRAIN) begin
      if (wcnt_q == '0) begin
        if (state_q == ST_RUN) begin
          wr_valid = 1'b1;
          wr_sof   = 1'b1;
          wr_data  = hdr_word(rate_q, seq_q);
        end
      end else if (!fifo_empty) begin
        wr_valid  = 1'b1;
        from_fifo = 1'b1;
        wr_data   = fifo_head;
        wr_eof    = last_word;
      end else if (state_q == ST_DRAIN) begin
        wr_valid = 1'b1;
        wr_data  = PAD;
        wr_eof   = last_word;
      end
    end
  end

  assign fire = wr_valid && wr_ready;

  always_comb begin
    state_d  = state_q;
    rate_d   = rate_q;
    nblk_d   = nblk_q;
    blkcnt_d = blkcnt_q;
    seq_d    = seq_q;
    wcnt_d   = wcnt_q;
    scnt_d   = scnt_q;
    ovr_d    = ovr_q;
    if (fire) begin
      if (last_word) begin
        wcnt_d   = '0;
        seq_d    = seq_q + 8'd1;
        blkcnt_d = blkcnt_q + 16'd1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    if (state_q == ST_RUN && drdy && fifo_full && !fifo_pop) ovr_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d  = ST_SETTLE;
          rate_d   = rate_cfg;
          nblk_d   = num_blocks;
          blkcnt_d = '0;
          seq_d    = '0;
          wcnt_d   = '0;
          scnt_d   = '0;
          ovr_d    = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (drdy) begin
          if (scnt_q == SCW'(SETTLE - 1)) state_d = ST_RUN;
          else scnt_d = scnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // A block is in progress if any of its words has been (or is being) accepted.
        if (fire && last_word && nblk_q != '0 && blkcnt_d == nblk_q) state_d = ST_IDLE;
        else if (stop) state_d = (wcnt_d != '0) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (fire && last_word) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rate_q   <= '0;
      nblk_q   <= '0;
      blkcnt_q <= '0;
      seq_q    <= '0;
      wcnt_q   <= '0;
      scnt_q   <= '0;
      ovr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rate_q   <= rate_d;
      nblk_q   <= nblk_d;
      blkcnt_q <= blkcnt_d;
      seq_q    <= seq_d;
      wcnt_q   <= wcnt_d;
      scnt_q   <= scnt_d;
      ovr_q    <= ovr_d;
      done_q   <= (state_q != ST_IDLE) && (state_d == ST_IDLE);
    end
  end

  assign rate      = rate_q;
  assign dec_reset = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_log_sequencer.sv
// Randomized bench for log_sequencer: a stream-level model fills a scoreboard queue, a monitor checks every handshake.
module tb_log_sequencer;
  localparam int BW = 8;
  localparam int FD = 16;
  localparam int ST = 4;
  localparam logic [15:0] PADW = 16'h8000;

  logic        clk = 1'b0;
  logic        reset, start, stop, drdy, wr_ready;
  logic [2:0]  rate_cfg, rate;
  logic [15:0] num_blocks, sample, wr_data;
  logic        dec_reset, wr_valid, wr_sof, wr_eof, busy, done, overrun;

  always #5 clk = ~clk;

  log_sequencer #(.BLOCK_WORDS(BW), .FIFO_DEPTH(FD), .SETTLE(ST)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .rate_cfg(rate_cfg),
    .num_blocks(num_blocks), .rate(rate), .dec_reset(dec_reset), .drdy(drdy),
    .sample(sample), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sof(wr_sof), .wr_eof(wr_eof), .busy(busy), .done(done), .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;

  // Model: expected stream entries are {sof, eof, data}.
  logic [17:0] exp_q[$];
  logic [2:0]  m_rate;
  logic [7:0]  m_seq;
  int          m_nblk, m_blkdone, m_pos, m_ndrdy;
  bit          m_busy = 1'b0;
  int          exp_done = 0;
  int          got_done = 0;
  int          rdy_mode = 2;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic m_header();
    exp_q.push_back({1'b1, 1'b0, 5'b10100, m_rate, m_seq});
    m_pos = 1;
  endtask

  task automatic m_word(input logic [15:0] d);
    bit eof;
    eof = (m_pos == BW - 1);
    exp_q.push_back({1'b0, eof, d});
    m_pos++;
    if (eof) begin
      m_pos = 0;
      m_seq++;
      m_blkdone++;
      if (m_busy) begin
        if (m_nblk != 0 && m_blkdone == m_nblk) begin
          m_busy = 1'b0;
          exp_done++;
        end else begin
          m_header();
        end
      end
    end
  endtask

  task automatic m_drdy(input logic [15:0] s, input int cap);
    if (!m_busy) return;
    m_ndrdy++;
    if (m_ndrdy <= ST) begin
      if (m_ndrdy == ST) m_header();
      return;
    end
    if (m_ndrdy - ST - 1 < cap) m_word(s);
  endtask

  task automatic m_stop();
    if (!m_busy) return;
    m_busy = 1'b0;
    exp_done++;
    if (m_ndrdy < ST) return;
    while (m_pos != 0) m_word(PADW);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] r, input logic [15:0] nb, input logic with_stop);
    rate_cfg = r;
    num_blocks = nb;
    start = 1'b1;
    stop = with_stop;
    if (!with_stop && !m_busy && exp_q.size() == 0) begin
      m_rate = r; m_seq = 8'd0; m_nblk = int'(nb); m_blkdone = 0; m_pos = 0; m_ndrdy = 0;
      m_busy = 1'b1;
    end
    tick();
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    m_stop();
    tick();
    stop = 1'b0;
  endtask

  task automatic give(input int n, input int gap, input int cap);
    for (int i = 0; i < n; i++) begin
      sample = 16'($urandom);
      drdy = 1'b1;
      m_drdy(sample, cap);
      tick();
      drdy = 1'b0;
      repeat (gap - 1) tick();
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d words still expected, busy=%0b, expected idle", name, exp_q.size(), busy);
      exp_q.delete();
    end
    tick();
    chk({name, "_done_count"}, got_done, exp_done);
  endtask

  initial begin
    wr_ready = 1'b0;
    forever begin
      tick();
      case (rdy_mode)
        0:       wr_ready = 1'b1;
        1:       wr_ready = ($urandom_range(3) != 0);
        default: wr_ready = 1'b0;
      endcase
    end
  end

  bit          prev_stall = 1'b0;
  logic [17:0] prev_word;
  logic [17:0] mon_exp;
  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", wr_valid, 1);
          chk("hold_word", {wr_sof, wr_eof, wr_data}, prev_word);
        end
        if (!wr_valid) chk("idle_data", wr_data, 0);
        if (wr_valid && wr_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word: got %h, expected no word", {wr_sof, wr_eof, wr_data});
          end else begin
            mon_exp = exp_q.pop_front();
            chk("stream_word", {wr_sof, wr_eof, wr_data}, mon_exp);
          end
        end
        if (done) begin
          got_done++;
          chk("done_busy", busy, 0);
          chk("done_dec_reset", dec_reset, 1);
        end
        prev_stall = wr_valid && !wr_ready;
        prev_word  = {wr_sof, wr_eof, wr_data};
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; stop = 1'b0; drdy = 1'b0; sample = '0;
    rate_cfg = '0; num_blocks = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dec_reset", dec_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rate", rate, 0);
    mon_en = 1'b1;

    // Two fixed-length blocks, a mid-block stall, a start ignored while running.
    rdy_mode = 0;
    do_start(3'd2, 16'd2, 1'b0);
    chk("s1_rate", rate, 2);
    chk("s1_dec_reset", dec_reset, 0);
    chk("s1_busy", busy, 1);
    give(ST, 4, 1000);
    give(3, 4, 1000);
    do_start(3'd5, 16'd9, 1'b0);
    chk("s1_rate_kept", rate, 2);
    give(3, 4, 1000);
    rdy_mode = 2;
    give(5, 4, 1000);
    rdy_mode = 1;
    give(5, 4, 1000);
    rdy_mode = 0;
    wait_idle("s1");
    chk("s1_end_dec_reset", dec_reset, 1);
    chk("s1_end_overrun", overrun, 0);

    // Overflow with the writer stalled: first FD samples survive.
    rdy_mode = 2;
    do_start(3'd1, 16'd0, 1'b0);
    give(ST + FD + 4, 1, FD);
    tick();
    chk("s2_overrun", overrun, 1);
    rdy_mode = 0;
    repeat (40) tick();
    chk("s2_overrun_sticky", overrun, 1);
    do_stop();
    wait_idle("s2");

    // Stop three samples into a block: padded completion.
    do_start(3'd4, 16'd0, 1'b0);
    chk("s3_overrun_cleared", overrun, 0);
    give(ST + 3, 3, 1000);
    repeat (5) tick();
    do_stop();
    wait_idle("s3");

    // Reset mid-block with a word pending.
    rdy_mode = 2;
    do_start(3'd6, 16'd0, 1'b0);
    give(ST + FD + 2, 1, FD);
    tick();
    chk("s4_pre_valid", wr_valid, 1);
    chk("s4_pre_overrun", overrun, 1);
    reset = 1'b1;
    exp_q.delete();
    m_busy = 1'b0;
    tick();
    reset = 1'b0;
    chk("s4_wr_valid", wr_valid, 0);
    chk("s4_busy", busy, 0);
    chk("s4_dec_reset", dec_reset, 1);
    chk("s4_overrun", overrun, 0);
    chk("s4_done", done, 0);
    chk("s4_rate", rate, 0);
    rdy_mode = 0;
    tick();
    do_start(3'd3, 16'd1, 1'b0);
    give(ST + BW - 1, 2, 1000);
    wait_idle("s4");

    // Stop during settling.
    do_start(3'd7, 16'd0, 1'b0);
    give(2, 2, 1000);
    do_stop();
    repeat (3) tick();
    chk("s5_busy", busy, 0);
    wait_idle("s5");

    // Start and stop together in IDLE.
    d0 = got_done;
    do_start(3'd5, 16'd3, 1'b1);
    chk("s6_busy", busy, 0);
    chk("s6_dec_reset", dec_reset, 1);
    repeat (3) tick();
    chk("s6_no_done", got_done, d0);

    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/log_sequencer.md
# log_sequencer

Capture-session controller for the decimation datapath. Latches the decimation rate, holds the decimation block in reset while idle, and discards the first filter-settling samples. Packs the decimated 16-bit samples into fixed-length blocks, each starting with a header word, and streams them to the storage writer over a valid/ready handshake. Reports overruns.

## Interface
- BLOCK_WORDS, 256: words per block, header included; ≥ 4.
- FIFO_DEPTH, 16: sample FIFO depth, power of two.
- SETTLE, 4: decimated samples discarded after the decimation block leaves reset.
- clk  in  1  system clock (only clock); reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse: begin a session; ignored unless IDLE.
- stop  in  1  one-cycle pulse: end the session.
- rate_cfg  in  3  decimation select, sampled on start.
- num_blocks  in  16  blocks per session, sampled on start; 0 = continuous.
- rate  out  3  latched rate to decimation block; reset 0.
- dec_reset  out  1  decimation block reset; 1 in IDLE; reset 1.
- drdy  in  1  decimated sample strobe.
- sample  in  16  decimated sample.
- wr_data  out  16  stream data; 0 when wr_valid=0.
- wr_valid  out  1  stream valid; reset 0.
- wr_ready  in  1  writer accepts a word when wr_valid and wr_ready are both 1.
- wr_sof  out  1  high with the header word.
- wr_eof  out  1  high with the last word of a block.
- busy  out  1  state ≠ IDLE; reset 0.
- done  out  1  one-cycle pulse on return to IDLE; reset 0.
- overrun  out  1  sticky sample drop; cleared on accepted start; reset 0.

## Operation
- States: IDLE → SETTLE → RUN → DRAIN → IDLE.
- IDLE: dec_reset=1, FIFO empty.
  - start (without stop in the same cycle) latches rate_cfg, num_blocks and clears overrun, seq and the word count, then enters SETTLE.
- SETTLE: dec_reset=0. Counts SETTLE drdy pulses and discards those samples, then enters RUN.
  - stop returns directly to IDLE; no words are emitted and done pulses.
- RUN: each drdy pushes sample into the FIFO.
  - The output side emits one block: a header word {5'b10100, rate, seq[7:0]}, then BLOCK_WORDS-1 FIFO words.
  - seq increments after each block's eof handshake and wraps at 255.
  - When the completed block count equals num_blocks (≠0), go to IDLE after that eof.
  - stop goes to DRAIN; if no block is in progress (word count 0) it goes to IDLE instead.
- DRAIN: drdy is ignored.
  - The FIFO content is emitted first; the rest of the current block is padded with PAD=16'h8000. Then go to IDLE.
  - The done pulse occurs in the cycle the state becomes IDLE.
- Overrun: drdy while the FIFO is full and there is no pop that cycle drops the sample and sets overrun. full + pop in the same cycle accepts the push.
- start or stop outside the states listed above has no effect.

## Timing
- drdy at cycle N → word in FIFO at N+1. It is presented on wr_data at N+1 if it is next in the block (FIFO is first-word-fall-through, registered storage).
- Header: wr_valid rises the cycle after the state becomes RUN and after each eof handshake, with no FIFO dependency.
- Once wr_valid is 1, wr_data, wr_sof and wr_eof are held until the handshake. wr_valid drops only after a handshake.
- One word per cycle maximum when wr_ready is held 1.
- dec_reset rises the same cycle the state enters IDLE.
- reset at any time: every output takes its reset value the next cycle, the FIFO empties, and no done pulse is generated.

## Structure
- Package log_pkg: state enum, HDR_TAG=5'b10100, PAD=16'h8000.
- Sub-module sync_fifo (FWFT, WIDTH, DEPTH, full/empty, push/pop, synchronous active-high reset).
- The top level contains the FSM, the settle/word/block/seq counters and the output mux (header/FIFO/pad).

## Test plan
- start, rate_cfg=3'd2, num_blocks=2, BLOCK_WORDS=8, drdy every 4 cycles, wr_ready=1 → SETTLE samples are dropped. Result: 16 words, headers 16'hA200/16'hA201, wr_sof and wr_eof on words 0/7 and 8/15, then done, busy=0, dec_reset=1.
- Same setup, wr_ready low for 20 cycles in mid-block → wr_data stable while stalled. FIFO_DEPTH=16 is not exceeded, so overrun stays 0 and no sample is lost or reordered.
- wr_ready held 0 and 17+ samples arrive → overrun=1 and exactly the first 16 samples are later emitted. The next start clears overrun.
- stop after 3 samples of the block → the block completes with 3 samples followed by 4 PAD words and a single eof; done pulses.
- reset asserted mid-block while wr_valid=1 → the next cycle has wr_valid=0, busy=0, dec_reset=1, overrun=0. A following start produces a header with seq 0.
- stop during SETTLE; start and stop in the same IDLE cycle; start while in RUN → the first returns to IDLE with no words, the second stays in IDLE, and the third is ignored.
